// File: rtl/coin_payout.sv
// Coin hopper payout controller: ejects COIN_VALUE coins one at a time until the
// requested credit is paid. Each coin is confirmed by a debounced exit sensor.
module coin_payout #(
   parameter int COIN_VALUE      = 5,
   parameter int MAX_AMOUNT      = 95,
   parameter int TIMEOUT_CYCLES  = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int GAP_CYCLES      = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] amount,
   input  logic       coin_sense,
   input  logic       clear_fault,
   output logic       hopper_en,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [6:0] remaining,
   output logic [4:0] coins_paid
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FEED  = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;
   localparam logic [1:0] FAULT = 2'd3;

   localparam int TIMER_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int TW        = $clog2(TIMER_MAX + 1);
   localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [6:0]    COIN         = 7'(COIN_VALUE);
   localparam logic [6:0]    MAX_AMT      = 7'(MAX_AMOUNT);
   localparam logic [4:0]    COINS_SAT    = 5'd31;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [TW-1:0] timer;
   logic          sync1;
   logic          sync2;
   logic          deb_level;
   logic [DW-1:0] deb_cnt;
   logic          coin_event;
   logic [6:0]    clamped;

   // Synchronize the sensor, then accept a level change only after it has
   // persisted; a coin is the rising edge of the accepted level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         deb_level <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         sync1 <= coin_sense;
         sync2 <= sync1;
         if (sync2 != deb_level) begin
            if (deb_cnt == DEB_LAST) begin
               deb_level <= sync2;
               deb_cnt   <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   assign coin_event = sync2 && !deb_level && (deb_cnt == DEB_LAST);
   assign clamped    = (amount > MAX_AMT) ? MAX_AMT : amount;
   assign busy       = (state != IDLE);
   assign fault      = (state == FAULT);

   // A coin arriving on the timeout cycle still counts, so it is tested first.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start && clamped >= COIN) next_state = FEED;
         FEED: begin
            if (coin_event)                 next_state = GAP;
            else if (timer == TIMEOUT_LAST) next_state = FAULT;
         end
         GAP:     if (timer == GAP_LAST) next_state = (remaining >= COIN) ? FEED : IDLE;
         FAULT:   if (clear_fault) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The timer restarts on every state change, so it serves both the feed
   // timeout and the inter-coin gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         hopper_en  <= 1'b0;
         done       <= 1'b0;
         remaining  <= 7'd0;
         coins_paid <= 5'd0;
      end else begin
         state     <= next_state;
         hopper_en <= (next_state == FEED);
         done      <= 1'b0;
         if (state != next_state)
            timer <= '0;
         else if (state == FEED || state == GAP)
            timer <= timer + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  remaining  <= clamped;
                  coins_paid <= 5'd0;
                  if (clamped < COIN) done <= 1'b1;
               end
            end
            FEED: begin
               if (coin_event) begin
                  remaining <= remaining - COIN;
                  if (coins_paid != COINS_SAT) coins_paid <= coins_paid + 1'b1;
               end
            end
            GAP: begin
               if (timer == GAP_LAST && remaining < COIN) done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_payout.sv
// Directed testbench for coin_payout using short timeout, debounce and gap
// parameters so full payouts fit in a few thousand cycles.
module tb_coin_payout;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [6:0] amount;
   logic       coin_sense;
   logic       clear_fault;
   logic       hopper_en;
   logic       busy;
   logic       done;
   logic       fault;
   logic [6:0] remaining;
   logic [4:0] coins_paid;

   int tests_run    = 0;
   int tests_failed = 0;

   int rise_count = 0;
   int done_count = 0;
   int high_run   = 0;
   int low_run    = 0;
   int last_high  = 0;
   int last_gap   = 0;
   logic prev_en  = 1'b0;

   coin_payout #(
      .COIN_VALUE(5),
      .MAX_AMOUNT(95),
      .TIMEOUT_CYCLES(100),
      .DEBOUNCE_CYCLES(4),
      .GAP_CYCLES(10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .amount(amount),
      .coin_sense(coin_sense),
      .clear_fault(clear_fault),
      .hopper_en(hopper_en),
      .busy(busy),
      .done(done),
      .fault(fault),
      .remaining(remaining),
      .coins_paid(coins_paid)
   );

   always #5 clk = ~clk;

   // Track hopper_en window lengths, rises and done pulses once per cycle.
   always @(negedge clk) begin
      if (hopper_en && !prev_en) begin
         last_gap = low_run;
         rise_count++;
         high_run = 1;
      end else if (hopper_en) begin
         high_run++;
      end else if (prev_en) begin
         last_high = high_run;
         low_run = 1;
      end else begin
         low_run++;
      end
      prev_en = hopper_en;
      if (done) done_count++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [6:0] a);
      amount = a;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   // Wait for the hopper to run, then present one 8-cycle coin 20 cycles later.
   task automatic pay_coin(input string tag);
      int n = 0;
      while (hopper_en !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      tests_run++;
      if (hopper_en !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL %s_hopper_rise: got %0b, expected 1", tag, hopper_en);
      end
      repeat (20) step();
      coin_sense = 1'b1;
      repeat (8) step();
      coin_sense = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL %s_done_seen: got %0b, expected 1", tag, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; amount = 7'd0; coin_sense = 1'b0; clear_fault = 1'b0;
      #1;
      tests_run++;
      if ({hopper_en, busy, done, fault, remaining, coins_paid} !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %h, expected 0", {hopper_en, busy, done, fault, remaining, coins_paid});
      end
      step(); step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_payout_15();
      int r0 = rise_count;
      int d0 = done_count;
      pulse_start(7'd15);
      tests_run++;
      if (hopper_en !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL p15_hopper_after_start: got en=%0b busy=%0b, expected 1 1", hopper_en, busy);
      end
      pay_coin("p15_c1");
      pay_coin("p15_c2");
      tests_run++;
      if (last_gap !== 10) begin
         tests_failed++;
         $display("[TB] FAIL p15_gap1: got %0d, expected 10", last_gap);
      end
      pay_coin("p15_c3");
      tests_run++;
      if (last_gap !== 10) begin
         tests_failed++;
         $display("[TB] FAIL p15_gap2: got %0d, expected 10", last_gap);
      end
      wait_done("p15");
      tests_run++;
      if (busy !== 1'b0 || remaining !== 7'd0 || coins_paid !== 5'd3) begin
         tests_failed++;
         $display("[TB] FAIL p15_final: got busy=%0b rem=%0d coins=%0d, expected 0 0 3", busy, remaining, coins_paid);
      end
      step(); step();
      tests_run++;
      if (done !== 1'b0 || done_count - d0 !== 1 || rise_count - r0 !== 3) begin
         tests_failed++;
         $display("[TB] FAIL p15_counts: got done=%0b pulses=%0d rises=%0d, expected 0 1 3", done, done_count - d0, rise_count - r0);
      end
      // A coin seen while idle must not disturb the held results.
      coin_sense = 1'b1;
      repeat (8) step();
      coin_sense = 1'b0;
      repeat (8) step();
      tests_run++;
      if (coins_paid !== 5'd3 || remaining !== 7'd0) begin
         tests_failed++;
         $display("[TB] FAIL idle_coin_ignored: got coins=%0d rem=%0d, expected 3 0", coins_paid, remaining);
      end
   endtask

   task automatic test_zero_amount();
      int r0 = rise_count;
      pulse_start(7'd0);
      tests_run++;
      if (done !== 1'b1 || hopper_en !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL zero_done_pulse: got done=%0b en=%0b busy=%0b, expected 1 0 0", done, hopper_en, busy);
      end
      step();
      tests_run++;
      if (done !== 1'b0 || remaining !== 7'd0 || coins_paid !== 5'd0) begin
         tests_failed++;
         $display("[TB] FAIL zero_after: got done=%0b rem=%0d coins=%0d, expected 0 0 0", done, remaining, coins_paid);
      end
      repeat (5) step();
      tests_run++;
      if (rise_count - r0 !== 0) begin
         tests_failed++;
         $display("[TB] FAIL zero_no_hopper: got %0d rises, expected 0", rise_count - r0);
      end
   endtask

   task automatic test_timeout_fault();
      int n = 0;
      pulse_start(7'd10);
      while (fault !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      tests_run++;
      if (fault !== 1'b1 || busy !== 1'b1 || hopper_en !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_fault: got fault=%0b busy=%0b en=%0b, expected 1 1 0", fault, busy, hopper_en);
      end
      repeat (5) step();
      tests_run++;
      if (last_high !== 100 || remaining !== 7'd10 || coins_paid !== 5'd0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_state: got high=%0d rem=%0d coins=%0d, expected 100 10 0", last_high, remaining, coins_paid);
      end
      // Start together with clear: clear wins and the start is dropped.
      clear_fault = 1'b1;
      amount      = 7'd20;
      start       = 1'b1;
      step();
      clear_fault = 1'b0;
      start       = 1'b0;
      tests_run++;
      if (fault !== 1'b0 || busy !== 1'b0 || remaining !== 7'd10) begin
         tests_failed++;
         $display("[TB] FAIL clear_fault: got fault=%0b busy=%0b rem=%0d, expected 0 0 10", fault, busy, remaining);
      end
      step();
      tests_run++;
      if (hopper_en !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL clear_start_ignored: got en=%0b busy=%0b, expected 0 0", hopper_en, busy);
      end
   endtask

   task automatic test_glitch();
      pulse_start(7'd10);
      repeat (10) step();
      coin_sense = 1'b1;
      repeat (2) step();
      coin_sense = 1'b0;
      repeat (10) step();
      tests_run++;
      if (remaining !== 7'd10 || coins_paid !== 5'd0 || hopper_en !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL glitch_ignored: got rem=%0d coins=%0d en=%0b, expected 10 0 1", remaining, coins_paid, hopper_en);
      end
      coin_sense = 1'b1;
      repeat (8) step();
      coin_sense = 1'b0;
      repeat (4) step();
      tests_run++;
      if (remaining !== 7'd5 || coins_paid !== 5'd1) begin
         tests_failed++;
         $display("[TB] FAIL glitch_real_coin: got rem=%0d coins=%0d, expected 5 1", remaining, coins_paid);
      end
      pay_coin("glitch_c2");
      wait_done("glitch");
      tests_run++;
      if (remaining !== 7'd0 || coins_paid !== 5'd2) begin
         tests_failed++;
         $display("[TB] FAIL glitch_final: got rem=%0d coins=%0d, expected 0 2", remaining, coins_paid);
      end
      step();
   endtask

   task automatic test_residual_and_clamp();
      pulse_start(7'd17);
      for (int i = 0; i < 3; i++) pay_coin("res");
      wait_done("res");
      tests_run++;
      if (remaining !== 7'd2 || coins_paid !== 5'd3) begin
         tests_failed++;
         $display("[TB] FAIL residual: got rem=%0d coins=%0d, expected 2 3", remaining, coins_paid);
      end
      step();
      pulse_start(7'd120);
      tests_run++;
      if (remaining !== 7'd95 || coins_paid !== 5'd0) begin
         tests_failed++;
         $display("[TB] FAIL clamp_load: got rem=%0d coins=%0d, expected 95 0", remaining, coins_paid);
      end
      for (int i = 0; i < 19; i++) pay_coin("clamp");
      wait_done("clamp");
      tests_run++;
      if (remaining !== 7'd0 || coins_paid !== 5'd19) begin
         tests_failed++;
         $display("[TB] FAIL clamp_final: got rem=%0d coins=%0d, expected 0 19", remaining, coins_paid);
      end
      step();
   endtask

   task automatic test_busy_start_and_reset();
      pulse_start(7'd20);
      repeat (5) step();
      pulse_start(7'd50);
      tests_run++;
      if (remaining !== 7'd20 || hopper_en !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL busy_start_ignored: got rem=%0d en=%0b, expected 20 1", remaining, hopper_en);
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({hopper_en, busy, done, fault, remaining, coins_paid} !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got %h, expected 0", {hopper_en, busy, done, fault, remaining, coins_paid});
      end
      step();
      reset = 1'b0;
      repeat (3) step();
      tests_run++;
      if (hopper_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL after_reset: got en=%0b busy=%0b done=%0b, expected 0 0 0", hopper_en, busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_payout_15();
      test_zero_amount();
      test_timeout_fault();
      test_glitch();
      test_residual_and_clamp();
      test_busy_start_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
